// File: rtl/adrv9001_tdd_seq_if.sv
// adrv9001_tdd_seq_if
//
// Bundles one channel's TDD control inputs and enable outputs.
//   master : the side that owns the timing registers and the request level
//            (register block / TDD controller); drives tdd_en, req and counts,
//            observes enable, ssi_enable, state and burst_cnt.
//   slave  : the sequencer itself.
//
// Signalling: there is no valid/ready handshake. Every signal is a level,
// synchronous to the sequencer clock, sampled on each rising edge; the
// counts are only read at phase boundaries (snapshotted), so the master may
// rewrite them at any time without a strobe.
interface adrv9001_tdd_seq_if #(
  parameter int CNT_W = 32
);
  logic             tdd_en;
  logic             req;
  logic [CNT_W-1:0] disable_cnt;
  logic [CNT_W-1:0] ssi_enable_cnt;
  logic [CNT_W-1:0] ssi_disable_cnt;
  logic             enable;
  logic             ssi_enable;
  logic [1:0]       state;
  logic [15:0]      burst_cnt;

  modport master (
    output tdd_en, req, disable_cnt, ssi_enable_cnt, ssi_disable_cnt,
    input  enable, ssi_enable, state, burst_cnt
  );

  modport slave (
    input  tdd_en, req, disable_cnt, ssi_enable_cnt, ssi_disable_cnt,
    output enable, ssi_enable, state, burst_cnt
  );
endinterface

// File: rtl/adrv9001_tdd_seq.sv
// adrv9001_tdd_seq
//
// Per-channel TDD enable sequencer. Drives the ADRV9001 enable pin and the
// SSI data-path gate with cycle-exact spacing derived from the timing counts.
//
// Ports:
//   clk  : SSI-domain clock
//   rst  : synchronous, active-high reset
//   bus  : adrv9001_tdd_seq_if.slave
//          in : tdd_en, req, disable_cnt, ssi_enable_cnt, ssi_disable_cnt
//          out: enable, ssi_enable, state (0 IDLE, 1 ENABLING, 2 ACTIVE,
//               3 DISABLING), burst_cnt
//
// Optional feature: define ADRV9001_TDD_SEQ_BURST_CNT_EN to build a 16-bit
// wrapping count of ssi_enable rising edges on burst_cnt; otherwise burst_cnt
// is tied to 0.
module adrv9001_tdd_seq #(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  adrv9001_tdd_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ENABLING  = 2'd1,
    S_ACTIVE    = 2'd2,
    S_DISABLING = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic             ssi_q, ssi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] n_snap_q, n_snap_d;
  logic [CNT_W-1:0] d_snap_q, d_snap_d;
  logic [CNT_W-1:0] s_snap_q, s_snap_d;
  logic             go_dis;

  // Outputs are registered so each edge lands in the cycle whose counter
  // value equals the snapshot: compare the incremented count, not the
  // current one.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    ssi_d    = ssi_q;
    cnt_d    = cnt_q;
    n_snap_d = n_snap_q;
    d_snap_d = d_snap_q;
    s_snap_d = s_snap_q;
    go_dis   = 1'b0;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    if (!bus.tdd_en) begin
      state_d = S_IDLE;
      en_d    = 1'b0;
      ssi_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          en_d  = 1'b0;
          ssi_d = 1'b0;
          cnt_d = '0;
          if (bus.req) begin
            en_d     = 1'b1;
            n_snap_d = bus.ssi_enable_cnt;
            // A zero ssi_enable_cnt raises both gates on the same edge.
            if (bus.ssi_enable_cnt == '0) begin
              ssi_d   = 1'b1;
              state_d = S_ACTIVE;
            end else begin
              state_d = S_ENABLING;
            end
          end
        end
        S_ENABLING: begin
          // A request drop wins over a coincident ssi_enable rise.
          if (!bus.req) begin
            go_dis = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == n_snap_q) begin
              ssi_d   = 1'b1;
              state_d = S_ACTIVE;
            end
          end
        end
        S_ACTIVE: begin
          if (!bus.req) go_dis = 1'b1;
        end
        S_DISABLING: begin
          // Leave only once both gates were already low for a full cycle.
          if (!en_q && !ssi_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == d_snap_q) en_d  = 1'b0;
            if (cnt_inc == s_snap_q) ssi_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (go_dis) begin
        state_d  = S_DISABLING;
        cnt_d    = '0;
        d_snap_d = bus.disable_cnt;
        s_snap_d = bus.ssi_disable_cnt;
        if (bus.disable_cnt == '0)     en_d  = 1'b0;
        if (bus.ssi_disable_cnt == '0) ssi_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      ssi_q    <= 1'b0;
      cnt_q    <= '0;
      n_snap_q <= '0;
      d_snap_q <= '0;
      s_snap_q <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      ssi_q    <= ssi_d;
      cnt_q    <= cnt_d;
      n_snap_q <= n_snap_d;
      d_snap_q <= d_snap_d;
      s_snap_q <= s_snap_d;
    end
  end

  assign bus.enable     = en_q;
  assign bus.ssi_enable = ssi_q;
  assign bus.state      = state_q;

`ifdef ADRV9001_TDD_SEQ_BURST_CNT_EN
  logic [15:0] burst_q;

  // Survives tdd_en drops; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q <= '0;
    end else if (ssi_d && !ssi_q) begin
      burst_q <= burst_q + 16'd1;
    end
  end

  assign bus.burst_cnt = burst_q;
`else
  assign bus.burst_cnt = '0;
`endif

endmodule

// File: tb/tb_adrv9001_tdd_seq.sv
// tb_adrv9001_tdd_seq
//
// Testbench for adrv9001_tdd_seq. Inputs are driven on the falling edge; a
// deadline-based reference model predicts the outputs after the following
// rising edge and pushes them to a queue; a monitor samples the DUT 1 ns
// after each rising edge and compares against the queue head.
module tb_adrv9001_tdd_seq;
  localparam int CNT_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adrv9001_tdd_seq_if #(.CNT_W(CNT_W)) bus ();

  adrv9001_tdd_seq #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          mon_cyc = 0;
  logic [19:0] mon_e, mon_a;

  // ---------------- reference model ----------------
  // Modes: 0 off/idle, 1 on (enable high, ssi pending or high), 2 winding down.
  // Edges are tracked as absolute cycle deadlines computed from the timing
  // rules rather than with a running counter.
  longint      t = 0;
  int          m_mode = 0;
  bit          m_en = 1'b0;
  bit          m_ssi = 1'b0;
  longint      m_ssi_at, m_en_off_at, m_ssi_off_at, m_idle_at;
  logic [15:0] m_burst = '0;
  logic [1:0]  m_state;

  longint unsigned cur_n = 0, cur_d = 0, cur_s = 0;

  function automatic longint max2(longint a, longint b);
    return (a > b) ? a : b;
  endfunction

  // Inputs sampled at the end of cycle t; updates the model to cycle t+1.
  function void model_step(bit r, bit te, bit rq);
    bit ssi_was;
    ssi_was = m_ssi;
    if (r) begin
      m_mode = 0; m_en = 0; m_ssi = 0; m_burst = '0;
    end else if (!te) begin
      m_mode = 0; m_en = 0; m_ssi = 0;
    end else begin
      case (m_mode)
        0: if (rq) begin
             m_mode   = 1;
             m_en     = 1;
             m_ssi_at = t + 1 + longint'(cur_n);
             m_ssi    = (cur_n == 0);
           end
        1: if (!rq) begin
             m_mode       = 2;
             m_en_off_at  = t + 1 + longint'(cur_d);
             m_ssi_off_at = t + 1 + longint'(cur_s);
             m_idle_at    = t + 2 + max2(longint'(cur_d), m_ssi ? longint'(cur_s) : 0);
             m_en         = m_en && (t + 1 < m_en_off_at);
             m_ssi        = m_ssi && (t + 1 < m_ssi_off_at);
           end else if (!m_ssi && (t + 1 >= m_ssi_at)) begin
             m_ssi = 1;
           end
        default: begin
          m_en  = m_en && (t + 1 < m_en_off_at);
          m_ssi = m_ssi && (t + 1 < m_ssi_off_at);
          if (t + 1 >= m_idle_at) m_mode = 0;
        end
      endcase
`ifdef ADRV9001_TDD_SEQ_BURST_CNT_EN
      if (m_ssi && !ssi_was) m_burst = m_burst + 16'd1;
`endif
    end
    case (m_mode)
      0:       m_state = 2'd0;
      1:       m_state = m_ssi ? 2'd2 : 2'd1;
      default: m_state = 2'd3;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit r, input bit te, input bit rq);
    @(negedge clk);
    rst                 = r;
    bus.tdd_en          = te;
    bus.req             = rq;
    bus.ssi_enable_cnt  = CNT_W'(cur_n);
    bus.disable_cnt     = CNT_W'(cur_d);
    bus.ssi_disable_cnt = CNT_W'(cur_s);
    model_step(r, te, rq);
    exp_q.push_back({m_state, m_en, m_ssi, m_burst});
    t++;
  endtask

  task automatic run(input int cycles, input bit rq);
    for (int i = 0; i < cycles; i++) drive(1'b0, 1'b1, rq);
  endtask

  task automatic set_cnt(input int n, input int d, input int s);
    cur_n = longint'(n);
    cur_d = longint'(d);
    cur_s = longint'(s);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {bus.state, bus.enable, bus.ssi_enable, bus.burst_cnt};
        checks++;
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got state=%0d enable=%b ssi_enable=%b burst_cnt=%0d, expected state=%0d enable=%b ssi_enable=%b burst_cnt=%0d",
                   mon_cyc, mon_a[19:18], mon_a[17], mon_a[16], mon_a[15:0],
                   mon_e[19:18], mon_e[17], mon_e[16], mon_e[15:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int on_len, off_len, drain;
  bit te_r;

  initial begin
    rst                 = 1'b1;
    bus.tdd_en          = 1'b0;
    bus.req             = 1'b0;
    bus.ssi_enable_cnt  = '0;
    bus.disable_cnt     = '0;
    bus.ssi_disable_cnt = '0;

    // Reset state
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
    run(3, 1'b0);

    // Nominal burst
    set_cnt(20, 100, 130);
    run(200, 1'b1);
    run(140, 1'b0);

    // Zero counts, a few back-to-back bursts
    set_cnt(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run(1 + i, 1'b1);
      run(2 + i, 1'b0);
    end

    // Abort during ENABLING: req drops 10 cycles after enable rises
    set_cnt(50, 30, 35);
    run(11, 1'b1);
    run(45, 1'b0);

    // Retrigger during DISABLING
    set_cnt(3, 40, 40);
    run(30, 1'b1);
    run(5, 1'b0);
    run(60, 1'b1);
    run(50, 1'b0);

    // tdd_en drop in ACTIVE, then rst in ACTIVE
    set_cnt(3, 8, 8);
    run(15, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    run(10, 1'b1);
    run(15, 1'b0);
    run(15, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    run(10, 1'b0);

    // Count rewrite mid-DISABLING has no effect on the current phase
    set_cnt(2, 100, 100);
    run(20, 1'b1);
    run(5, 1'b0);
    set_cnt(2, 10, 100);
    run(110, 1'b0);

    // Randomized bursts, including mid-phase count writes, TX-style S=D,
    // sporadic tdd_en drops and resets
    for (int b = 0; b < 60; b++) begin
      cur_n = $urandom_range(0, 12);
      cur_d = $urandom_range(0, 15);
      cur_s = (b % 3 == 0) ? cur_d : longint'($urandom_range(0, 15));
      on_len  = $urandom_range(1, 25);
      off_len = $urandom_range(1, 30);
      for (int i = 0; i < on_len; i++) begin
        te_r = ($urandom_range(0, 39) != 0);
        if ($urandom_range(0, 9) == 0) cur_n = $urandom_range(0, 12);
        drive(1'b0, te_r, 1'b1);
      end
      for (int i = 0; i < off_len; i++) begin
        if ($urandom_range(0, 7) == 0) cur_d = $urandom_range(0, 15);
        if ($urandom_range(0, 7) == 0) cur_s = $urandom_range(0, 15);
        drive(1'b0, 1'b1, ($urandom_range(0, 15) == 0));
      end
      if (b % 17 == 9) drive(1'b1, 1'b1, 1'b0);
    end
    run(40, 1'b0);

    // Drain the scoreboard within a bounded number of cycles
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adrv9001_tdd_seq.md
# adrv9001_tdd_seq

Per-channel TDD enable sequencer for the ADRV9001 data path. It sits directly downstream of the ADRV9001 register block. It consumes one channel's `*_tdd_en` and timing counts (`*_disable_cnt`, `*_ssi_enable_cnt`, `*_ssi_disable_cnt`) plus a TDD request level, and produces the device enable pin drive and the SSI data-path gate with cycle-exact spacing. Four instances (TX1, TX2, RX1, RX2) run in the SSI clock domain. TX instances tie `ssi_disable_cnt` to `disable_cnt`.

## Interface
- `CNT_W`, default 32: width of all timing counts and the internal counter.
- `clk` input 1: SSI-domain clock, the only clock.
- `rst` input 1: reset, synchronous and active-high.
- `tdd_en` input 1: sequencer enable; low forces IDLE.
- `req` input 1: TDD request level (high = channel on), already synchronous to `clk`.
- `disable_cnt` input CNT_W: cycles from accepted `req` fall to `enable` fall.
- `ssi_enable_cnt` input CNT_W: cycles from `enable` rise to `ssi_enable` rise.
- `ssi_disable_cnt` input CNT_W: cycles from accepted `req` fall to `ssi_enable` fall.
- `enable` output 1: drive to the ADRV9001 TX/RX enable pin.
- `ssi_enable` output 1: gate for the SSI transmit/capture path.
- `state` output 2: FSM state, encoded 0=IDLE, 1=ENABLING, 2=ACTIVE, 3=DISABLING.
- `burst_cnt` output 16: number of `ssi_enable` rising edges. Present only with the macro in Configuration; otherwise constant 0.

## Operation
- All outputs registered. Reset values: `enable`=0, `ssi_enable`=0, `state`=IDLE, `burst_cnt`=0, internal counter=0.
- Counts are snapshotted into internal registers on entry to ENABLING (`ssi_enable_cnt`) and on entry to DISABLING (`disable_cnt`, `ssi_disable_cnt`). Register writes mid-phase have no effect until the next phase.
- IDLE: `enable`=0 and `ssi_enable`=0. Go to ENABLING when `req`=1 and `tdd_en`=1.
- ENABLING: `enable`=1 and the counter increments from 0. When the counter equals the `ssi_enable_cnt` snapshot, set `ssi_enable` and go to ACTIVE. A snapshot of 0 sets `ssi_enable` together with `enable`.
- ACTIVE: both outputs high. On `req`=0, go to DISABLING with the counter cleared.
- `req`=0 during ENABLING aborts the phase and goes to DISABLING. `ssi_enable` stays 0 for that burst.
- DISABLING: the counter increments each cycle.
  - `enable` clears when the counter equals the `disable_cnt` snapshot.
  - `ssi_enable` clears when the counter equals the `ssi_disable_cnt` snapshot.
  - Either edge may come first. A zero count clears the output in the first DISABLING cycle.
  - Go to IDLE in the cycle after both outputs are low.
  - `req` is ignored in this state; IDLE re-samples it.
- `tdd_en`=0 in any state: the next cycle has `state`=IDLE and both outputs 0, aborting immediately. `rst` has the same effect and also clears `burst_cnt`.
- The counter saturates at all-ones. It never wraps.

## Timing
- `req` rises, sampled at edge T in IDLE: `enable`=1 from T+1. `ssi_enable`=1 from T+1+N, where N = `ssi_enable_cnt`.
- `req` falls, sampled at edge T in ACTIVE: `enable`=0 from T+1+D and `ssi_enable`=0 from T+1+S, where D = `disable_cnt` and S = `ssi_disable_cnt`. `state`=IDLE from T+2+max(D,S).
- Minimum off time: a `req` re-rise is first acted on in IDLE, one cycle after the last output falls.
- `tdd_en` or `rst` to outputs low: exactly one cycle.

## Configuration
- `ADRV9001_TDD_SEQ_BURST_CNT_EN`:
  - Defined: `burst_cnt` is a 16-bit counter that increments on every `ssi_enable` rising edge. It wraps from 0xFFFF to 0 and is cleared only by `rst`.
  - Undefined: no counter logic; `burst_cnt` is tied to 0.

## Test plan
- Nominal burst: N=20, D=100, S=130, `req` high for 200 cycles. Expected: `enable` high 1 cycle after `req`; `ssi_enable` rises 20 cycles after `enable`; `enable` falls 101 cycles after `req` falls; `ssi_enable` falls 131 cycles after `req` falls; IDLE at 132.
- Zero counts: N=D=S=0. Expected: `enable` and `ssi_enable` rise and fall together, each 1 cycle after the corresponding `req` edge.
- Abort in ENABLING: N=50, `req` drops 10 cycles after `enable`. Expected: `ssi_enable` never rises; `enable` falls per D; `burst_cnt` unchanged.
- Retrigger during DISABLING: D=S=40, `req` re-rises 5 cycles after falling. Expected: outputs still fall at +41; `enable` re-rises at +43.
- Mid-burst `tdd_en`=0 in ACTIVE. Expected: both outputs 0 and `state`=0 next cycle. Same check with `rst`=1, plus `burst_cnt`=0.
- Mid-phase count write: change `disable_cnt` from 100 to 10 during DISABLING. Expected: `enable` still falls at +101. With the macro defined, 65537 bursts give `burst_cnt`=1.
